// File: rtl/seq_divider_if.sv
// Request/result bundle between the pipeline and the iterative divider.
// Operands travel with Start; results are held until the next Done.
interface seq_divider_if;
  logic        Start;
  logic        Signed;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  modport master (
    output Start, Signed, Dividend, Divisor,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Signed, Dividend, Divisor,
    output Busy, Done, Quotient, Remainder, DivByZero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract 32-bit divider: one quotient bit per clock, 34-cycle latency.
// Start is only taken in IDLE/DONE; the pipeline stalls on Busy, so Start during Busy is dropped.
module seq_divider (
  input logic          Clk,
  input logic          Reset,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] part_rem;
  logic [31:0] quo_reg;
  logic [31:0] dvs_mag;
  logic [5:0]  count;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [32:0] trial;
  logic [31:0] shifted_rem;
  logic        dvd_neg;
  logic        dvs_neg;

  always_comb begin
    dvd_neg     = bus.Signed & bus.Dividend[31];
    dvs_neg     = bus.Signed & bus.Divisor[31];
    dvd_abs     = dvd_neg ? (32'd0 - bus.Dividend) : bus.Dividend;
    dvs_abs     = dvs_neg ? (32'd0 - bus.Divisor) : bus.Divisor;
    // partial_rem < divisor always holds, so a set bit 32 means the subtraction borrowed
    trial       = {part_rem, quo_reg[31]} - {1'b0, dvs_mag};
    shifted_rem = {part_rem[30:0], quo_reg[31]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      part_rem      <= 32'd0;
      quo_reg       <= 32'd0;
      dvs_mag       <= 32'd0;
      count         <= 6'd0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.Busy      <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Quotient  <= 32'd0;
      bus.Remainder <= 32'd0;
      bus.DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            neg_r    <= dvd_neg;
            neg_q    <= dvd_neg ^ dvs_neg;
            quo_reg  <= dvd_abs;
            dvs_mag  <= dvs_abs;
            part_rem <= 32'd0;
            count    <= 6'd32;
            if (bus.Divisor == 32'd0) begin
              // Results are published immediately; the raw dividend is the remainder
              state         <= DONE;
              bus.Done      <= 1'b1;
              bus.Quotient  <= 32'hFFFF_FFFF;
              bus.Remainder <= bus.Dividend;
              bus.DivByZero <= 1'b1;
            end else begin
              state    <= RUN;
              bus.Busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          quo_reg  <= {quo_reg[30:0], ~trial[32]};
          part_rem <= trial[32] ? shifted_rem : trial[31:0];
          count    <= count - 6'd1;
          if (count == 6'd1) begin
            state <= FIX;
          end
        end

        FIX: begin
          bus.Quotient  <= neg_q ? (32'd0 - quo_reg)  : quo_reg;
          bus.Remainder <= neg_r ? (32'd0 - part_rem) : part_rem;
          bus.DivByZero <= 1'b0;
          bus.Done      <= 1'b1;
          bus.Busy      <= 1'b0;
          state         <= DONE;
        end

        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
          bus.Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at Start, checked on Done.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          busy;
    int          start_cyc;
  } exp_t;

  typedef struct {
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  seq_divider_if bus ();

  seq_divider dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always @(posedge Clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb_;
    sa = a;
    sb_ = b;
    e.dbz = 1'b0;
    e.lat = 34;
    e.busy = 33;
    e.start_cyc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dbz = 1'b1;
      e.lat = 1;
      e.busy = 0;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (sg) begin
      e.q = sa / sb_;
      e.r = sa % sb_;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: result checks on Done, hold checks on every other cycle
  int          busy_cnt = 0;
  bit          prev_rst = 1'b1;
  logic [31:0] last_q, last_r;
  logic        last_dbz;

  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      busy_cnt = 0;
      prev_rst = 1'b1;
    end else begin
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        check_val("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("quotient", bus.Quotient, e.q);
          check_val("remainder", bus.Remainder, e.r);
          check_val("div_by_zero", 32'(bus.DivByZero), 32'(e.dbz));
          check_val("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          check_val("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
      end else if (!prev_rst) begin
        check_val("hold_quotient", bus.Quotient, last_q);
        check_val("hold_remainder", bus.Remainder, last_r);
        check_val("hold_dbz", 32'(bus.DivByZero), 32'(last_dbz));
      end
      prev_rst = 1'b0;
    end
    last_q   = bus.Quotient;
    last_r   = bus.Remainder;
    last_dbz = bus.DivByZero;
  end

  // Called just after a rising edge; leaves Start low one edge later with scrambled operands
  task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    exp_t x;
    x = e;
    bus.Start    = 1'b1;
    bus.Signed   = sg;
    bus.Dividend = a;
    bus.Divisor  = b;
    x.start_cyc  = cyc;
    sb.push_back(x);
    @(posedge Clk);
    #1;
    bus.Start    = 1'b0;
    bus.Signed   = 1'($urandom);
    bus.Dividend = $urandom;
    bus.Divisor  = $urandom;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge Clk);
    check_val("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    exp_t e;
    bit          sg;
    logic [31:0] a, b;

    vecs[0] = '{0, 32'd100,         32'd7,         32'd14,         32'd2,          1'b0};
    vecs[1] = '{1, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{1, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000,  32'd0,          1'b0};
    vecs[4] = '{0, 32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[5] = '{0, 32'd3,           32'hFFFF_FFFF, 32'd0,          32'd3,          1'b0};
    vecs[6] = '{0, 32'd5,           32'd0,         32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[7] = '{0, 32'd9,           32'd3,         32'd3,          32'd0,          1'b0};
    vecs[8] = '{1, 32'hFFFF_FFF0,   32'd0,         32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};

    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Signed   = 1'b0;
    bus.Dividend = 32'd0;
    bus.Divisor  = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_busy", 32'(bus.Busy), 32'd0);
    check_val("rst_done", 32'(bus.Done), 32'd0);
    check_val("rst_quotient", bus.Quotient, 32'd0);
    check_val("rst_remainder", bus.Remainder, 32'd0);
    check_val("rst_dbz", 32'(bus.DivByZero), 32'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Directed vectors with hand-derived results; latency follows divisor
    foreach (vecs[i]) begin
      e     = model(vecs[i].sg, vecs[i].a, vecs[i].b);
      e.q   = vecs[i].q;
      e.r   = vecs[i].r;
      e.dbz = vecs[i].dbz;
      issue(vecs[i].sg, vecs[i].a, vecs[i].b, e);
      wait_drain();
    end

    // Start during Busy (cycle 10 of the operation) must be dropped
    issue(0, 32'd1000, 32'd9, model(0, 32'd1000, 32'd9));
    repeat (9) @(posedge Clk);
    #1;
    bus.Start    = 1'b1;
    bus.Dividend = 32'd77;
    bus.Divisor  = 32'd1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    wait_drain();

    // Start held in the Done cycle chains a second operation
    issue(1, 32'hFFFF_FF00, 32'd5, model(1, 32'hFFFF_FF00, 32'd5));
    for (int i = 0; i < 60 && !bus.Done; i++) begin
      @(posedge Clk);
      #1;
    end
    check_val("b2b_first_done", 32'(bus.Done), 32'd1);
    issue(0, 32'd123456, 32'd789, model(0, 32'd123456, 32'd789));
    wait_drain();

    // Reset in cycle 12 of 100/7 discards the operation
    issue(0, 32'd100, 32'd7, model(0, 32'd100, 32'd7));
    repeat (11) @(posedge Clk);
    #1;
    Reset = 1'b1;
    sb.delete();
    @(posedge Clk);
    #1;
    check_val("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check_val("mid_rst_done", 32'(bus.Done), 32'd0);
    check_val("mid_rst_quotient", bus.Quotient, 32'd0);
    check_val("mid_rst_remainder", bus.Remainder, 32'd0);
    check_val("mid_rst_dbz", 32'(bus.DivByZero), 32'd0);
    Reset = 1'b0;
    repeat (40) @(posedge Clk);
    #1;

    // Random mix, with an occasional zero divisor and small divisors
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      issue(sg, a, b, model(sg, a, b));
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
